z16_button_conditioner: RTL
===========================

# z16_button_conditioner

Conditions the raw, active-low board push-button into clean events for the Z16 CPU. Sits between the button pad and the CPU's `i_button` input, in the fast board clock domain ahead of the CPU clock divider. It synchronises and debounces the pad and provides a debounced level. It also provides a press event that is held valid until acknowledged, so the slow CPU clock cannot miss it.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000: stable-input cycles required before the debounced level changes (10 ms at 27 MHz); minimum 2.
- `CNT_WIDTH`, default 25: counter width; must hold `max(DEBOUNCE_CYCLES, LONG_CYCLES)`.
- `LONG_CYCLES`, default 27_000_000: hold time for a long press (1 s); only used with `Z16_BTN_LONGPRESS_EN`.
- `i_clk`, in, 1: board clock. This is the only clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_button_n`, in, 1: raw pad, active-low, asynchronous, bouncy.
- `i_press_ack`, in, 1: consumer acknowledge for `o_press_valid`.
- `o_button`, out, 1: debounced level, 1 = pressed.
- `o_press_valid`, out, 1: a press event is pending.
- `o_overrun`, out, 1: sticky flag; a press occurred while one was already pending.
- `o_long_press`, out, 1: one-cycle pulse on long press; constant 0 without the macro.

## Operation
- **Synchroniser:** two flops on `~i_button_n` produce `sync`. Both flops reset to 0 (released).
- **FSM states:**
  - `RELEASED`: `o_button`=0. If `sync`=1, clear the counter and go to `CHK_PRESS`.
  - `CHK_PRESS`: if `sync`=0, return to `RELEASED`. Otherwise increment the counter. When the counter reaches `DEBOUNCE_CYCLES-1`, go to `PRESSED` and raise the press event.
  - `PRESSED`: `o_button`=1. If `sync`=0, clear the counter and go to `CHK_RELEASE`.
  - `CHK_RELEASE`: if `sync`=1, return to `PRESSED` with no event. On the count reaching `DEBOUNCE_CYCLES-1`, go to `RELEASED`.
- **Bounce handling:** any bounce shorter than `DEBOUNCE_CYCLES` produces no level change and no event.
- **Press event:** sets `o_press_valid`=1. A cycle with `i_press_ack`=1 and `o_press_valid`=1 clears it. `i_press_ack` while `o_press_valid`=0 is ignored.
- **Ack and new press in the same cycle:** `o_press_valid` stays 1. `o_overrun` is not set, because the old event is consumed.
- **Press while pending:** a new press event with `o_press_valid`=1 and no ack sets `o_overrun`=1. `o_overrun` clears only on reset.
- **Counter:** unsigned `CNT_WIDTH` bits. It never wraps; it stops at its terminal count in every state.
- **Reset values:**
  - FSM: `RELEASED`; counter 0.
  - `o_button`=0, `o_press_valid`=0, `o_overrun`=0, `o_long_press`=0.
- **Reset mid-operation:** reset during `CHK_*` or while an event is pending discards everything. No event is generated after reset for a button that is already held until it is seen stable for `DEBOUNCE_CYCLES`. A button held through reset therefore yields exactly one press event, `2+DEBOUNCE_CYCLES` cycles after reset deasserts.

## Timing
- **Press latency:** pad falls and stays low before edge k. `sync`=1 after edge k+1. `o_button` and `o_press_valid` rise after edge k+1+`DEBOUNCE_CYCLES`. Release latency is the same.
- **Ack path:** `o_press_valid` falls the cycle after the acked edge, with one-cycle ack-to-clear latency. A combinational path from ack to valid is not allowed.
- **Registering:** all outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **`Z16_BTN_LONGPRESS_EN` defined:**
  - In `PRESSED`, a second counter increments each cycle and saturates.
  - When it reaches `LONG_CYCLES-1`, `o_long_press` pulses for exactly one cycle.
  - At most one pulse is produced per press; the counter clears on leaving `PRESSED` or on reset.
  - A long press does not affect `o_press_valid`.
- **Undefined:** no second counter is built, and `o_long_press` is tied to 0.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=20.
- **Reset:** assert `i_rst` with the pad high, then release. All outputs are 0 and stay 0 for 50 cycles.
- **Clean press:** pad low from edge 10, held. `o_button` and `o_press_valid` go to 1 after edge 15. Ack at edge 20 gives `o_press_valid`=0 after edge 20. `o_button` stays 1.
- **Bounce:** pad toggles low/high every 2 cycles for 20 cycles, then stays high. There are no events and `o_button` stays 0. Pad-high glitches of 3 cycles during a held press produce no release.
- **Overrun and ack collision:**
  - Two debounced presses with no ack: `o_overrun`=1 after the second.
  - After reset, a second press coinciding with ack: `o_press_valid`=1 and `o_overrun`=0.
- **Reset mid-debounce:** pad held low, with reset pulsed during `CHK_PRESS`. Exactly one press event appears, 6 cycles after reset release.
- **Long press (macro defined):** a press held 30 cycles gives a single `o_long_press` pulse 20 cycles after entering `PRESSED`. With the macro undefined, `o_long_press` is 0 throughout.

Source files
------------

// File: rtl/z16_button_conditioner.sv
// z16_button_conditioner
// Conditions the raw active-low board push-button for the Z16 CPU:
//   - two-flop synchroniser on the inverted pad
//   - four-state debounce FSM producing a clean level (o_button)
//   - sticky press event (o_press_valid) held until acknowledged, so a
//     slow consumer clock cannot miss it, plus a sticky overrun flag
//   - optional long-press pulse, built only when Z16_BTN_LONGPRESS_EN is
//     defined; otherwise o_long_press is tied low and no counter exists.
// Handshake: o_press_valid rises on a debounced press and stays high until
// a cycle in which i_press_ack=1 and o_press_valid=1 (the transfer cycle);
// it falls one cycle after that transfer. i_press_ack with no event
// pending is ignored. A new press landing in the transfer cycle keeps
// o_press_valid high without setting o_overrun (the old event was taken).
// All outputs are registered; there is no combinational input-to-output path.
// dbg_state exposes the debounce FSM state for observation.
module z16_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int CNT_WIDTH       = 25,
  parameter int LONG_CYCLES     = 27_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_button_n,
  input  logic       i_press_ack,
  output logic       o_button,
  output logic       o_press_valid,
  output logic       o_overrun,
  output logic       o_long_press,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    PRESSED     = 2'd2,
    CHK_RELEASE = 2'd3
  } state_t;

  // Largest count any counter in this block has to reach; counters stop there.
  localparam int MAX_CYCLES = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_TERM = CNT_WIDTH'(MAX_CYCLES - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 deb_done;
  logic                 press_evt;
  logic                 sync_meta;
  logic                 sync;

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt >= CNT_TERM) ? cnt : cnt + CNT_WIDTH'(1);

  // The stable run is complete on the cycle whose increment reaches DEBOUNCE_CYCLES-1.
  assign deb_done = (cnt_inc >= CNT_LAST);

  // A debounced press is committed on this edge.
  assign press_evt = (state == CHK_PRESS) && sync && deb_done;

  assign dbg_state = state;

  // Two-flop synchroniser on the inverted pad (1 = pressed), reset to released.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= ~i_button_n;
      sync      <= sync_meta;
    end
  end

  // Debounce FSM: the level only changes after a full stable run of sync.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= RELEASED;
      cnt      <= '0;
      o_button <= 1'b0;
    end else begin
      case (state)
        RELEASED: begin
          o_button <= 1'b0;
          if (sync) begin
            cnt   <= '0;
            state <= CHK_PRESS;
          end
        end
        CHK_PRESS: begin
          if (!sync) begin
            state <= RELEASED;
          end else begin
            cnt <= cnt_inc;
            if (deb_done) begin
              state    <= PRESSED;
              o_button <= 1'b1;
            end
          end
        end
        PRESSED: begin
          o_button <= 1'b1;
          if (!sync) begin
            cnt   <= '0;
            state <= CHK_RELEASE;
          end
        end
        CHK_RELEASE: begin
          if (sync) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt_inc;
            if (deb_done) begin
              state    <= RELEASED;
              o_button <= 1'b0;
            end
          end
        end
        default: begin
          state    <= RELEASED;
          cnt      <= '0;
          o_button <= 1'b0;
        end
      endcase
    end
  end

  // Pending press event with acknowledge, and sticky overrun on an unconsumed event.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_press_valid <= 1'b0;
      o_overrun     <= 1'b0;
    end else if (press_evt) begin
      o_press_valid <= 1'b1;
      if (o_press_valid && !i_press_ack) begin
        o_overrun <= 1'b1;
      end
    end else if (i_press_ack && o_press_valid) begin
      o_press_valid <= 1'b0;
    end
  end

`ifdef Z16_BTN_LONGPRESS_EN
  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_CYCLES - 1);

  logic [CNT_WIDTH-1:0] long_cnt;
  logic                 long_fired;

  // Long-press timer: counts cycles spent in PRESSED, one pulse per press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      long_cnt     <= '0;
      long_fired   <= 1'b0;
      o_long_press <= 1'b0;
    end else if (state == PRESSED) begin
      if (long_cnt != LONG_LAST) begin
        long_cnt <= long_cnt + CNT_WIDTH'(1);
      end
      o_long_press <= (long_cnt == LONG_LAST) && !long_fired;
      if (long_cnt == LONG_LAST) begin
        long_fired <= 1'b1;
      end
    end else begin
      long_cnt     <= '0;
      long_fired   <= 1'b0;
      o_long_press <= 1'b0;
    end
  end
`else
  // No long-press timer in this build.
  assign o_long_press = 1'b0;
`endif

endmodule
